ball_collision_check: RTL

BALL_COLLISION_CHECK -- requirements
Module: ball_collision_check

---
 rtl/labyrinth_pkg.sv | 22 ++
 rtl/tile_classify.sv | 26 ++
 rtl/ball_collision_check.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/labyrinth_pkg.sv
// Shared labyrinth definitions: map tile codes and the collision-check FSM state encoding.
package labyrinth_pkg;

    typedef enum logic [1:0] {
        TILE_OPEN = 2'd0,
        TILE_WALL = 2'd1,
        TILE_HOLE = 2'd2,
        TILE_GOAL = 2'd3
    } tile_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_XY,
        EV_XY,
        RD_X,
        EV_X,
        RD_Y,
        EV_Y,
        DONE
    } state_t;

endpackage

// File: rtl/tile_classify.sv
// Combinational map-bounds test plus tile decode for one candidate cell.
module tile_classify
    import labyrinth_pkg::*;
#(
    parameter int COORD_WIDTH = 8,
    parameter int MAP_W       = 160,
    parameter int MAP_H       = 120
) (
    input  logic [COORD_WIDTH-1:0] cand_x,
    input  logic [COORD_WIDTH-1:0] cand_y,
    input  logic [1:0]             tile,
    output logic                   x_in,
    output logic                   y_in,
    output logic [1:0]             cls
);

    localparam logic [COORD_WIDTH:0] X_LIM = (COORD_WIDTH+1)'(MAP_W);
    localparam logic [COORD_WIDTH:0] Y_LIM = (COORD_WIDTH+1)'(MAP_H);

    assign x_in = {1'b0, cand_x} < X_LIM;
    assign y_in = {1'b0, cand_y} < Y_LIM;

    // Off-map cells behave as walls regardless of what the ROM returns.
    assign cls = (x_in && y_in) ? tile : TILE_WALL;

endmodule

// File: rtl/ball_collision_check.sv
// Resolves a proposed ball move against an external map ROM: commit, slide along a wall,
// stop at a wall, or respawn after a hole.
module ball_collision_check
    import labyrinth_pkg::*;
#(
    parameter int COORD_WIDTH = 8,
    parameter int MAP_W       = 160,
    parameter int MAP_H       = 120,
    parameter int START_X     = 1,
    parameter int START_Y     = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [COORD_WIDTH-1:0]   req_x,
    input  logic [COORD_WIDTH-1:0]   req_y,
    output logic                     req_ready,
    output logic [2*COORD_WIDTH-1:0] map_addr,
    input  logic [1:0]               map_data,
    output logic [COORD_WIDTH-1:0]   x_out,
    output logic [COORD_WIDTH-1:0]   y_out,
    output logic                     done,
    output logic                     hit_wall,
    output logic                     fell_hole,
    output logic                     at_goal,
    output logic [2:0]               state_dbg
);

    // Handshake: a request transfers on a rising edge with req_valid && req_ready; req_ready is
    // high only in IDLE, and a request seen while busy is dropped (upstream re-proposes every tick).

    localparam logic [COORD_WIDTH-1:0] START_XC = COORD_WIDTH'(START_X);
    localparam logic [COORD_WIDTH-1:0] START_YC = COORD_WIDTH'(START_Y);

    state_t state, state_n;
    logic [COORD_WIDTH-1:0] tx, ty, tgt_x, tgt_y, cand_x, cand_y, commit_x, commit_y;
    logic [2*COORD_WIDTH-1:0] addr_n;
    logic x_in, y_in, y_try_ok, diag;
    logic [1:0] cls;
    logic accept, load_addr, commit, set_hit, set_hole, set_goal;

    assign req_ready = (state == IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;

    // In IDLE the live request is the target; afterwards the latched copy is used.
    always_comb begin
        tgt_x  = tx;
        tgt_y  = ty;
        if (state == IDLE) begin
            tgt_x = req_x;
            tgt_y = req_y;
        end
        cand_x = tgt_x;
        cand_y = tgt_y;
        if (state == RD_X || state == EV_X) cand_y = y_out;
        if (state == RD_Y || state == EV_Y) cand_x = x_out;
    end

    assign diag = (tgt_x != x_out) && (tgt_y != y_out);

    tile_classify #(
        .COORD_WIDTH(COORD_WIDTH),
        .MAP_W      (MAP_W),
        .MAP_H      (MAP_H)
    ) u_classify (
        .cand_x(cand_x),
        .cand_y(cand_y),
        .tile  (map_data),
        .x_in  (x_in),
        .y_in  (y_in),
        .cls   (cls)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        load_addr = 1'b0;
        addr_n    = '0;
        commit    = 1'b0;
        commit_x  = cand_x;
        commit_y  = cand_y;
        set_hit   = 1'b0;
        set_hole  = 1'b0;
        set_goal  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_x == x_out && req_y == y_out) begin
                        state_n = DONE;
                    end else if (x_in && y_in) begin
                        state_n   = RD_XY;
                        load_addr = 1'b1;
                        addr_n    = {req_y, req_x};
                    end else if (diag && x_in) begin
                        state_n   = RD_X;
                        load_addr = 1'b1;
                        addr_n    = {y_out, req_x};
                    end else if (diag && y_in) begin
                        state_n   = RD_Y;
                        load_addr = 1'b1;
                        addr_n    = {req_y, x_out};
                    end else begin
                        state_n = DONE;
                        set_hit = 1'b1;
                    end
                end
            end
            RD_XY: state_n = EV_XY;
            RD_X:  state_n = EV_X;
            RD_Y:  state_n = EV_Y;
            EV_XY, EV_X, EV_Y: begin
                state_n = DONE;
                if (cls == TILE_WALL) begin
                    if (state == EV_XY && diag) begin
                        state_n   = RD_X;
                        load_addr = 1'b1;
                        addr_n    = {y_out, tx};
                    end else if (state == EV_X && y_try_ok) begin
                        state_n   = RD_Y;
                        load_addr = 1'b1;
                        addr_n    = {ty, x_out};
                    end else begin
                        set_hit = 1'b1;
                    end
                end else begin
                    commit = 1'b1;
                    if (cls == TILE_HOLE) begin
                        set_hole = 1'b1;
                        commit_x = START_XC;
                        commit_y = START_YC;
                    end
                    if (cls == TILE_GOAL) set_goal = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx        <= '0;
            ty        <= '0;
            y_try_ok  <= 1'b0;
            map_addr  <= '0;
            x_out     <= START_XC;
            y_out     <= START_YC;
            hit_wall  <= 1'b0;
            fell_hole <= 1'b0;
            at_goal   <= 1'b0;
        end else begin
            if (accept) begin
                tx        <= req_x;
                ty        <= req_y;
                y_try_ok  <= y_in;
                hit_wall  <= 1'b0;
                fell_hole <= 1'b0;
            end
            if (load_addr) map_addr <= addr_n;
            if (set_hit)   hit_wall <= 1'b1;
            if (commit) begin
                x_out <= commit_x;
                y_out <= commit_y;
            end
            if (set_hole) begin
                fell_hole <= 1'b1;
                at_goal   <= 1'b0;
            end
            if (set_goal) at_goal <= 1'b1;
        end
    end

endmodule
